// File: rtl/sr_s2p_param_if.sv
// Bus bundle for the serial-to-parallel deserialiser: serial input side,
// control strobes and the held-word valid/ready output port.
interface sr_s2p_param_if #(
    parameter int WIDTH = 8
);
    logic                         data_in;
    logic                         enable;
    logic                         flush;
    logic                         clr_ovf;
    logic                         out_ready;
    logic [WIDTH-1:0]             data_out;
    logic                         out_valid;
    logic [$clog2(WIDTH+1)-1:0]   bit_count;
    logic                         overflow;

    modport master (
        output data_in, enable, flush, clr_ovf, out_ready,
        input  data_out, out_valid, bit_count, overflow
    );

    modport slave (
        input  data_in, enable, flush, clr_ovf, out_ready,
        output data_out, out_valid, bit_count, overflow
    );
endinterface

// File: rtl/sr_s2p_param.sv
// Parametrised serial-to-parallel shift register. Collects WIDTH serial bits,
// hands the finished word to a held valid/ready output register, supports a
// partial-word flush and flags dropped words with a sticky overflow bit.
// reset_i is synchronous and active-low.
module sr_s2p_param #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    sr_s2p_param_if.slave      bus_if
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic [WIDTH-1:0] dataOut_q, dataOut_d;
    logic [CW-1:0]    bitCount_q, bitCount_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] shiftNext;
    logic             lastBit;
    logic             complete;

    // Shift register contents after taking this cycle's bit, and whether that bit finishes a word
    always_comb begin
        if (MSB_FIRST) begin
            shiftNext = {shiftReg_q[WIDTH-2:0], bus_if.data_in};
        end else begin
            shiftNext = {bus_if.data_in, shiftReg_q[WIDTH-1:1]};
        end
        lastBit  = (bitCount_q == CW'(WIDTH - 1));
        complete = bus_if.enable && !bus_if.flush && lastBit;
    end

    // Collection path, output FSM and sticky overflow next-state
    always_comb begin
        shiftReg_d = shiftReg_q;
        bitCount_d = bitCount_q;
        dataOut_d  = dataOut_q;
        state_d    = state_q;
        overflow_d = overflow_q;

        if (bus_if.flush) begin
            shiftReg_d = '0;
            bitCount_d = '0;
        end else if (bus_if.enable) begin
            shiftReg_d = shiftNext;
            bitCount_d = lastBit ? '0 : bitCount_q + CW'(1);
        end

        if (bus_if.clr_ovf) begin
            overflow_d = 1'b0;
        end

        unique case (state_q)
            EMPTY: begin
                if (complete) begin
                    dataOut_d = shiftNext;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    if (bus_if.out_ready) begin
                        dataOut_d = shiftNext;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (bus_if.out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= EMPTY;
            shiftReg_q <= '0;
            dataOut_q  <= '0;
            bitCount_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            dataOut_q  <= dataOut_d;
            bitCount_q <= bitCount_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus_if.data_out  = dataOut_q;
    assign bus_if.out_valid = (state_q == FULL);
    assign bus_if.bit_count = bitCount_q;
    assign bus_if.overflow  = overflow_q;
endmodule

// File: tb/tb_sr_s2p_param.sv
// Self-checking bench for sr_s2p_param. Three instances (8-bit MSB-first,
// 8-bit LSB-first, 12-bit MSB-first) share one input stream and are compared
// every cycle against a bit-list reference model, plus directed scenarios.
module tb_sr_s2p_param;
    logic clk;
    logic rstN;
    logic en, din, fl, rdy, clr;

    int checkCount = 0;
    int passCount  = 0;

    sr_s2p_param_if #(.WIDTH(8))  busA ();
    sr_s2p_param_if #(.WIDTH(8))  busB ();
    sr_s2p_param_if #(.WIDTH(12)) busC ();

    assign busA.data_in = din; assign busA.enable = en; assign busA.flush = fl;
    assign busA.out_ready = rdy; assign busA.clr_ovf = clr;
    assign busB.data_in = din; assign busB.enable = en; assign busB.flush = fl;
    assign busB.out_ready = rdy; assign busB.clr_ovf = clr;
    assign busC.data_in = din; assign busC.enable = en; assign busC.flush = fl;
    assign busC.out_ready = rdy; assign busC.clr_ovf = clr;

    sr_s2p_param #(.WIDTH(8),  .MSB_FIRST(1'b1)) dutA (.clk_i(clk), .reset_i(rstN), .bus_if(busA));
    sr_s2p_param #(.WIDTH(8),  .MSB_FIRST(1'b0)) dutB (.clk_i(clk), .reset_i(rstN), .bus_if(busB));
    sr_s2p_param #(.WIDTH(12), .MSB_FIRST(1'b1)) dutC (.clk_i(clk), .reset_i(rstN), .bus_if(busC));

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: bits of the current word as a list, plus the held word state
    int          mW[3]   = '{8, 8, 12};
    bit          mMsb[3] = '{1'b1, 1'b0, 1'b1};
    int          mCnt[3];
    bit          mBits[3][64];
    logic [63:0] mHeld[3];
    bit          mValid[3];
    bit          mOvf[3];

    function automatic logic [63:0] buildWord(int i);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < mW[i]; k++) begin
            if (mMsb[i]) w[mW[i] - 1 - k] = mBits[i][k];
            else         w[k]            = mBits[i][k];
        end
        return w;
    endfunction

    task automatic modelStep(input bit r, input bit e, input bit d, input bit f,
                             input bit rd, input bit c);
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                mCnt[i] = 0; mHeld[i] = '0; mValid[i] = 1'b0; mOvf[i] = 1'b0;
            end else begin
                bit          done;
                bit          newOvf;
                logic [63:0] word;
                done = 1'b0;
                word = '0;
                if (f) begin
                    mCnt[i] = 0;
                end else if (e) begin
                    mBits[i][mCnt[i]] = d;
                    if (mCnt[i] == mW[i] - 1) begin
                        word    = buildWord(i);
                        done    = 1'b1;
                        mCnt[i] = 0;
                    end else begin
                        mCnt[i]++;
                    end
                end
                newOvf = c ? 1'b0 : mOvf[i];
                if (done) begin
                    if (!mValid[i] || rd) begin
                        mHeld[i]  = word;
                        mValid[i] = 1'b1;
                    end else begin
                        newOvf = 1'b1;
                    end
                end else if (mValid[i] && rd) begin
                    mValid[i] = 1'b0;
                end
                mOvf[i] = newOvf;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed=%0h expected=%0h @%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("A.data",  64'(busA.data_out),  mHeld[0]);
        checkOutput("A.valid", 64'(busA.out_valid), 64'(mValid[0]));
        checkOutput("A.count", 64'(busA.bit_count), 64'(mCnt[0]));
        checkOutput("A.ovf",   64'(busA.overflow),  64'(mOvf[0]));
        checkOutput("B.data",  64'(busB.data_out),  mHeld[1]);
        checkOutput("B.valid", 64'(busB.out_valid), 64'(mValid[1]));
        checkOutput("B.count", 64'(busB.bit_count), 64'(mCnt[1]));
        checkOutput("B.ovf",   64'(busB.overflow),  64'(mOvf[1]));
        checkOutput("C.data",  64'(busC.data_out),  mHeld[2]);
        checkOutput("C.valid", 64'(busC.out_valid), 64'(mValid[2]));
        checkOutput("C.count", 64'(busC.bit_count), 64'(mCnt[2]));
        checkOutput("C.ovf",   64'(busC.overflow),  64'(mOvf[2]));
    endtask

    // Drive one cycle of inputs, advance past the edge, update the model and compare
    task automatic applyStimulus(input bit r, input bit e, input bit d, input bit f,
                                 input bit rd, input bit c);
        rstN = r; en = e; din = d; fl = f; rdy = rd; clr = c;
        @(posedge clk);
        #1;
        modelStep(r, e, d, f, rd, c);
        checkAll();
    endtask

    // Send the low n bits of value, most significant of them first
    task automatic sendBits(input logic [63:0] value, input int n, input bit rdBody, input bit rdLast);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, 1'b1, value[n - 1 - k], 1'b0, (k == n - 1) ? rdLast : rdBody, 1'b0);
        end
    endtask

    // Clear partial words, accept any held word and clear overflow
    task automatic realign();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    // Directed scenarios followed by a randomized run
    initial begin
        rstN = 1'b0; en = 1'b0; din = 1'b0; fl = 1'b0; rdy = 1'b0; clr = 1'b0;

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst.data",  64'(busA.data_out),  64'h0);
        checkOutput("rst.valid", 64'(busA.out_valid), 64'h0);
        checkOutput("rst.count", 64'(busA.bit_count), 64'h0);

        sendBits(64'hB2, 8, 1'b0, 1'b0);
        checkOutput("t1.msb",   64'(busA.data_out),  64'hB2);
        checkOutput("t1.valid", 64'(busA.out_valid), 64'h1);
        checkOutput("t1.count", 64'(busA.bit_count), 64'h0);
        checkOutput("t2.lsb",   64'(busB.data_out),  64'h4D);

        realign();
        sendBits(64'h7FF, 11, 1'b0, 1'b0);
        checkOutput("t2.peak",  64'(busC.bit_count), 64'd11);
        sendBits(64'h1, 1, 1'b0, 1'b0);
        checkOutput("t2.w12",   64'(busC.data_out),  64'hFFF);
        checkOutput("t2.v12",   64'(busC.out_valid), 64'h1);

        realign();
        sendBits(64'hA5, 8, 1'b0, 1'b0);
        sendBits(64'h3C, 8, 1'b0, 1'b0);
        checkOutput("t3.held",  64'(busA.data_out),  64'hA5);
        checkOutput("t3.ovf",   64'(busA.overflow),  64'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3.clr",   64'(busA.overflow),  64'h0);

        realign();
        sendBits(64'hA5, 8, 1'b0, 1'b0);
        sendBits(64'h3C, 8, 1'b0, 1'b1);
        checkOutput("t4.data",  64'(busA.data_out),  64'h3C);
        checkOutput("t4.valid", 64'(busA.out_valid), 64'h1);
        checkOutput("t4.ovf",   64'(busA.overflow),  64'h0);

        realign();
        sendBits(64'h15, 5, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        sendBits(64'h81, 8, 1'b0, 1'b0);
        checkOutput("t5.data",  64'(busA.data_out),  64'h81);
        sendBits(64'h7F, 7, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("t5.count", 64'(busA.bit_count), 64'h0);
        checkOutput("t5.valid", 64'(busA.out_valid), 64'h0);

        realign();
        sendBits(64'hC3, 8, 1'b0, 1'b0);
        sendBits(64'h5, 4, 1'b0, 1'b0);
        checkOutput("t6.pre",   64'(busA.bit_count), 64'h4);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t6.valid", 64'(busA.out_valid), 64'h0);
        checkOutput("t6.count", 64'(busA.bit_count), 64'h0);
        checkOutput("t6.data",  64'(busA.data_out),  64'h0);

        for (int n = 0; n < 1500; n++) begin
            applyStimulus($urandom_range(0, 99) != 0,
                          ($urandom % 4) != 0,
                          1'($urandom),
                          $urandom_range(0, 29) == 0,
                          ($urandom % 3) == 0,
                          $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
